// File: rtl/core_mem_arb.sv
// core_mem_arb: N-port arbiter onto one fixed-latency RAM port with size/alignment checking.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module core_mem_arb #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RAM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_wen,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [2*NUM_REQ-1:0]  req_size,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic                  rsp_err,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  ram_en,
    output logic                  ram_wen,
    output logic [AW-1:0]         ram_addr,
    output logic [1:0]            ram_size,
    output logic [DW-1:0]         ram_din,
    input  logic [DW-1:0]         ram_rdata
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(RAM_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FAULT} state_t;
    state_t             r_state;
    logic [GW-1:0]      r_gnt;
    logic [CW-1:0]      r_cnt;
    logic               r_wr;
    logic [NUM_REQ-1:0] w_req;
    logic [GW-1:0]      w_idx;
    logic               w_any;
    logic [AW-1:0]      w_addr;
    logic [1:0]         w_size;
    logic               w_legal;
    // The port being acked this cycle has been consumed and must not be re-granted.
    assign w_req = req & ~req_ack;
`ifdef MEM_ARB_RR_EN
    logic [GW-1:0] r_last;
    always_comb begin
        w_idx = '0;
        w_any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (w_req[(int'(r_last) + k) % NUM_REQ]) begin
                w_idx = GW'((int'(r_last) + k) % NUM_REQ);
                w_any = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req[i]) w_idx = GW'(i);
        end
    end
    assign w_any = |w_req;
`endif
    assign w_addr  = req_addr[int'(w_idx)*AW +: AW];
    assign w_size  = req_size[int'(w_idx)*2 +: 2];
    assign w_legal = (w_size == 2'b00) || (w_size == 2'b01 && !w_addr[0]) ||
                     (w_size == 2'b10 && w_addr[1:0] == 2'b00);
    // Read data is taken straight from the RAM in the response cycle, when it is valid.
    assign rsp_rdata = (|rsp_valid && !rsp_err && !r_wr) ? ram_rdata : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_wr      <= 1'b0;
            req_ack   <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            ram_en    <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_size  <= '0;
            ram_din   <= '0;
`ifdef MEM_ARB_RR_EN
            r_last    <= GW'(NUM_REQ - 1);
`endif
        end else begin
            req_ack   <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            ram_en    <= 1'b0;
            ram_wen   <= 1'b0;
            case (r_state)
                ISSUE: begin
                    r_cnt   <= CW'(RAM_LAT - 1);
                    r_state <= (RAM_LAT == 1) ? IDLE : WAIT;
                    if (RAM_LAT == 1) rsp_valid <= NUM_REQ'(1) << r_gnt;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt <= CW'(1)) begin
                        r_state   <= IDLE;
                        rsp_valid <= NUM_REQ'(1) << r_gnt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    if (w_any) begin
                        r_gnt   <= w_idx;
                        req_ack <= NUM_REQ'(1) << w_idx;
`ifdef MEM_ARB_RR_EN
                        r_last  <= w_idx;
`endif
                        if (w_legal) begin
                            r_state  <= ISSUE;
                            r_wr     <= req_wen[w_idx];
                            ram_en   <= 1'b1;
                            ram_wen  <= req_wen[w_idx];
                            ram_addr <= w_addr;
                            ram_size <= w_size;
                            ram_din  <= req_wdata[int'(w_idx)*DW +: DW];
                        end else begin
                            r_state   <= FAULT;
                            r_wr      <= 1'b0;
                            rsp_valid <= NUM_REQ'(1) << w_idx;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_mem_arb.sv
// tb_core_mem_arb: directed checks of core_mem_arb at RAM_LAT=1 (dut_a) and RAM_LAT=3 (dut_b).
module tb_core_mem_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  a_req, a_wen, a_ack, a_rsp, b_req, b_wen, b_ack, b_rsp;
    logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_size, b_size;
    logic        a_err, a_en, a_rwen, b_err, b_en, b_rwen;
    logic [31:0] a_rdata, a_raddr, a_din, a_ram_rdata, b_rdata, b_raddr, b_din, b_ram_rdata;
    logic [1:0]  a_rsize, b_rsize;
    logic [31:0] a_s = '0, b_s0 = '0, b_s1 = '0, b_s2 = '0;
    int          n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    core_mem_arb #(.NUM_REQ(2), .AW(32), .DW(32), .RAM_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .req_wen(a_wen), .req_addr(a_addr),
        .req_size(a_size), .req_wdata(a_wdata), .req_ack(a_ack), .rsp_valid(a_rsp),
        .rsp_err(a_err), .rsp_rdata(a_rdata), .ram_en(a_en), .ram_wen(a_rwen),
        .ram_addr(a_raddr), .ram_size(a_rsize), .ram_din(a_din), .ram_rdata(a_ram_rdata));

    core_mem_arb #(.NUM_REQ(2), .AW(32), .DW(32), .RAM_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .req_wen(b_wen), .req_addr(b_addr),
        .req_size(b_size), .req_wdata(b_wdata), .req_ack(b_ack), .rsp_valid(b_rsp),
        .rsp_err(b_err), .rsp_rdata(b_rdata), .ram_en(b_en), .ram_wen(b_rwen),
        .ram_addr(b_raddr), .ram_size(b_rsize), .ram_din(b_din), .ram_rdata(b_ram_rdata));

    // RAM models: data f(addr) appears exactly RAM_LAT cycles after ram_en, junk otherwise
    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction
    always @(posedge clk) begin
        a_s  <= a_en ? f(a_raddr) : 32'hBAD0BAD0;
        b_s0 <= b_en ? f(b_raddr) : 32'hBAD0BAD0;
        b_s1 <= b_s0;
        b_s2 <= b_s1;
    end
    assign a_ram_rdata = a_s;
    assign b_ram_rdata = b_s2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_g [4];

    initial begin
        rst_n = 1'b0;
        a_req = '0; a_wen = '0; a_addr = '0; a_size = '0; a_wdata = '0;
        b_req = '0; b_wen = '0; b_addr = '0; b_size = '0; b_wdata = '0;
        #12;
        chk("rst_ack", a_ack, 0);
        chk("rst_rsp", a_rsp, 0);
        chk("rst_en", a_en, 0);
        chk("rst_addr", a_raddr, 0);
        chk("rst_size", a_rsize, 0);
        chk("rst_din", a_din, 0);
        chk("rst_rdata", a_rdata, 0);
        tick;
        rst_n = 1'b1;
        tick;
        // single read, port 0
        a_req = 2'b01; a_addr[31:0] = 32'h100; a_size[1:0] = 2'b10;
        tick;
        chk("rd_en", a_en, 1);
        chk("rd_wen", a_rwen, 0);
        chk("rd_addr", a_raddr, 32'h100);
        chk("rd_size", a_rsize, 2'b10);
        chk("rd_ack", a_ack, 2'b01);
        chk("rd_rsp_early", a_rsp, 0);
        a_req = '0;
        tick;
        chk("rd_rsp", a_rsp, 2'b01);
        chk("rd_err", a_err, 0);
        chk("rd_rdata", a_rdata, 32'hDEADBEEF);
        chk("rd_en_off", a_en, 0);
        tick;
        chk("rd_rsp_off", a_rsp, 0);
        // write, port 1
        a_req = 2'b10; a_wen = 2'b10; a_addr[63:32] = 32'h204; a_size[3:2] = 2'b01; a_wdata[63:32] = 32'h1234;
        tick;
        chk("wr_en", a_en, 1);
        chk("wr_wen", a_rwen, 1);
        chk("wr_din", a_din, 32'h1234);
        chk("wr_addr", a_raddr, 32'h204);
        chk("wr_ack", a_ack, 2'b10);
        a_req = '0; a_wen = '0;
        tick;
        chk("wr_wen_off", a_rwen, 0);
        chk("wr_din_hold", a_din, 32'h1234);
        chk("wr_rsp", a_rsp, 2'b10);
        chk("wr_rdata", a_rdata, 0);
        tick;
        // contention: both ports held continuously
`ifdef MEM_ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        a_req = 2'b11; a_addr = {32'h20, 32'h10}; a_size = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("ct_ack%0d", k), a_ack, exp_g[k]);
            chk($sformatf("ct_en%0d", k), a_en, 1);
            tick;
            chk($sformatf("ct_rsp%0d", k), a_rsp, exp_g[k]);
            chk($sformatf("ct_rdata%0d", k), a_rdata, f(exp_g[k] == 2'b01 ? 32'h10 : 32'h20));
        end
        a_req = '0;
        tick;
        chk("ct_idle", a_ack, 0);
        // faults: misaligned half, illegal size, misaligned word
        a_req = 2'b01; a_addr[31:0] = 32'h3; a_size[1:0] = 2'b01;
        tick;
        chk("f1_ack", a_ack, 2'b01);
        chk("f1_rsp", a_rsp, 2'b01);
        chk("f1_err", a_err, 1);
        chk("f1_en", a_en, 0);
        chk("f1_rdata", a_rdata, 0);
        a_req = '0;
        tick;
        chk("f1_rsp_off", a_rsp, 0);
        chk("f1_err_off", a_err, 0);
        a_req = 2'b10; a_addr[63:32] = 32'h0; a_size[3:2] = 2'b11;
        tick;
        chk("f2_ack", a_ack, 2'b10);
        chk("f2_rsp", a_rsp, 2'b10);
        chk("f2_err", a_err, 1);
        chk("f2_en", a_en, 0);
        a_req = '0;
        tick;
        a_req = 2'b01; a_addr[31:0] = 32'h102; a_size[1:0] = 2'b10;
        tick;
        chk("f3_err", a_err, 1);
        chk("f3_en", a_en, 0);
        a_req = '0;
        tick;
        // legal half at addr 2
        a_req = 2'b01; a_addr[31:0] = 32'h2; a_size[1:0] = 2'b01;
        tick;
        chk("h_en", a_en, 1);
        chk("h_size", a_rsize, 2'b01);
        a_req = '0;
        tick;
        chk("h_rsp", a_rsp, 2'b01);
        chk("h_err", a_err, 0);
        chk("h_rdata", a_rdata, f(32'h2));
        tick;
        // RAM_LAT=3 read with port0 request pending during WAIT
        b_req = 2'b10; b_addr[63:32] = 32'h40; b_size[3:2] = 2'b10;
        tick;
        chk("l3_en", b_en, 1);
        chk("l3_ack", b_ack, 2'b10);
        chk("l3_addr", b_raddr, 32'h40);
        b_req = 2'b01; b_addr[31:0] = 32'h80; b_size[1:0] = 2'b00;
        tick;
        chk("l3_w1_en", b_en, 0);
        chk("l3_w1_ack", b_ack, 0);
        chk("l3_w1_rsp", b_rsp, 0);
        tick;
        chk("l3_w2_ack", b_ack, 0);
        chk("l3_w2_rsp", b_rsp, 0);
        tick;
        chk("l3_rsp", b_rsp, 2'b10);
        chk("l3_rdata", b_rdata, f(32'h40));
        chk("l3_rsp_ack", b_ack, 0);
        tick;
        chk("l3_ack2", b_ack, 2'b01);
        chk("l3_en2", b_en, 1);
        chk("l3_addr2", b_raddr, 32'h80);
        chk("l3_size2", b_rsize, 2'b00);
        b_req = '0;
        tick;
        tick;
        chk("l3_rsp2_early", b_rsp, 0);
        tick;
        chk("l3_rsp2", b_rsp, 2'b01);
        chk("l3_rdata2", b_rdata, f(32'h80));
        tick;
        // reset in the middle of WAIT
        b_req = 2'b01; b_addr[31:0] = 32'h100; b_size[1:0] = 2'b10;
        tick;
        chk("mr_en", b_en, 1);
        b_req = '0;
        tick;
        rst_n = 1'b0;
        #1;
        chk("mr_addr", b_raddr, 0);
        chk("mr_size", b_rsize, 0);
        chk("mr_rsp", b_rsp, 0);
        chk("mr_ack", b_ack, 0);
        chk("mr_en0", b_en, 0);
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("mr_norsp%0d", k), b_rsp, 0);
        end
        b_req = 2'b10; b_wen = 2'b10; b_addr[63:32] = 32'h8; b_size[3:2] = 2'b10; b_wdata[63:32] = 32'h55;
        tick;
        chk("mr_wr_ack", b_ack, 2'b10);
        chk("mr_wr_en", b_en, 1);
        chk("mr_wr_wen", b_rwen, 1);
        chk("mr_wr_din", b_din, 32'h55);
        b_req = '0; b_wen = '0;
        tick;
        tick;
        chk("mr_wr_rsp_early", b_rsp, 0);
        tick;
        chk("mr_wr_rsp", b_rsp, 2'b10);
        chk("mr_wr_err", b_err, 0);
        chk("mr_wr_rdata", b_rdata, 0);
        tick;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
